adc_spi_responder: RTL and testbench

Synthesizable responder for the 4-wire LTC2308-style serial ADC interface: the device end of the link that the ADC controller in `ADC_Data` drives. It answers the controller's CONVST/SCK/SDI frames with 12-bit samples drawn from a channel-indexed data source, and captures the 6-bit config word shifted in on SDI. It sits in loopback builds and benches in place of the physical ADC, so the averaging, voltage and distance path can be driven with known codes.

---
 rtl/adc_spi_responder.sv | 141 ++++++++++++++
 tb/tb_adc_spi_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_responder.sv
// Device-side model of an LTC2308-style 4-wire serial ADC. It answers CONVST/SCK/SDI frames
// with 12-bit samples from a channel-indexed source and captures the 6-bit config word.
module adc_spi_responder #(
    parameter int unsigned DATA_WIDTH  = 12,
    parameter int unsigned CFG_WIDTH   = 6,
    parameter int unsigned CONV_CYCLES = 80
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  adc_convst,
    input  logic                  adc_sck,
    input  logic                  adc_sdi,
    output logic                  adc_sdo,
    output logic [2:0]            ch_sel,
    input  logic [DATA_WIDTH-1:0] ch_data,
    output logic [CFG_WIDTH-1:0]  cfg_out,
    output logic                  cfg_valid,
    output logic                  busy,
    output logic                  frame_error
);

    localparam int unsigned CntW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam int unsigned BitW = $clog2(DATA_WIDTH + 1);
    localparam logic [CntW-1:0] ConvLoad = CntW'(CONV_CYCLES - 1);
    localparam logic [BitW-1:0] CfgBits  = BitW'(CFG_WIDTH);
    localparam logic [BitW-1:0] DataBits = BitW'(DATA_WIDTH);

    typedef enum logic [1:0] {StIdle, StConvert, StShift} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CFG_WIDTH-1:0]  cfg_shift_q, cfg_shift_d;
    logic [CFG_WIDTH-1:0]  cfg_q, cfg_d;
    logic [CntW-1:0]       conv_cnt_q, conv_cnt_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                  sdo_q, sdo_d;
    logic                  cfg_valid_q, cfg_valid_d;
    logic                  frame_error_q, frame_error_d;

    // Two synchronizer stages plus one history stage for edge detection.
    logic [2:0] convst_sync, sck_sync;
    logic [1:0] sdi_sync;
    logic       convst_rise, sck_rise, sck_fall, sdi_s;

    assign convst_rise = convst_sync[1] & ~convst_sync[2];
    assign sck_rise    = sck_sync[1] & ~sck_sync[2];
    assign sck_fall    = ~sck_sync[1] & sck_sync[2];
    assign sdi_s       = sdi_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            convst_sync   <= '0;
            sck_sync      <= '0;
            sdi_sync      <= '0;
            state_q       <= StIdle;
            shift_q       <= '0;
            cfg_shift_q   <= '0;
            cfg_q         <= '0;
            conv_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            sdo_q         <= 1'b0;
            cfg_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            convst_sync   <= {convst_sync[1:0], adc_convst};
            sck_sync      <= {sck_sync[1:0], adc_sck};
            sdi_sync      <= {sdi_sync[0], adc_sdi};
            state_q       <= state_d;
            shift_q       <= shift_d;
            cfg_shift_q   <= cfg_shift_d;
            cfg_q         <= cfg_d;
            conv_cnt_q    <= conv_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            sdo_q         <= sdo_d;
            cfg_valid_q   <= cfg_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        cfg_shift_d   = cfg_shift_q;
        cfg_d         = cfg_q;
        conv_cnt_d    = conv_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        cfg_valid_d   = 1'b0;
        frame_error_d = 1'b0;
        // SDO is registered so the MSB appears one clk after busy drops.
        sdo_d         = (state_q == StShift) ? shift_q[DATA_WIDTH-1] : 1'b0;

        if (convst_rise) begin
            // CONVST has priority; any SCK edge detected this cycle is dropped.
            frame_error_d = (state_q != StIdle);
            shift_d       = ch_data;
            conv_cnt_d    = ConvLoad;
            bit_cnt_d     = '0;
            cfg_shift_d   = '0;
            state_d       = StConvert;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StConvert: begin
                    frame_error_d = sck_rise;
                    if (conv_cnt_q == '0) begin
                        state_d = StShift;
                    end else begin
                        conv_cnt_d = conv_cnt_q - CntW'(1);
                    end
                end
                StShift: begin
                    if (sck_rise) begin
                        if (bit_cnt_q < CfgBits) begin
                            cfg_shift_d = {cfg_shift_q[CFG_WIDTH-2:0], sdi_s};
                        end
                        if (bit_cnt_q < DataBits) begin
                            bit_cnt_d = bit_cnt_q + BitW'(1);
                        end
                    end else if (sck_fall) begin
                        shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
                        if (bit_cnt_q == DataBits) begin
                            cfg_d       = cfg_shift_q;
                            cfg_valid_d = 1'b1;
                            state_d     = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign adc_sdo     = sdo_q;
    assign busy        = (state_q == StConvert);
    assign cfg_out     = cfg_q;
    assign ch_sel      = cfg_q[4:2];
    assign cfg_valid   = cfg_valid_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: plays the ADC controller at clk/8 SCK and checks every frame
// against a channel-source model with one-frame config pipelining.
module tb_adc_spi_responder;

    localparam int CONV = 80;

    logic        clk = 1'b0;
    logic        reset;
    logic        adc_convst, adc_sck, adc_sdi;
    logic        adc_sdo;
    logic [2:0]  ch_sel;
    logic [11:0] ch_data;
    logic [5:0]  cfg_out;
    logic        cfg_valid, busy, frame_error;

    logic [11:0] src [8];
    logic [5:0]  model_cfg;
    int          passed = 0;
    int          total  = 0;
    int          fe_cnt = 0;
    int          cv_cnt = 0;

    always #5 clk = ~clk;

    assign ch_data = src[ch_sel];

    adc_spi_responder #(
        .DATA_WIDTH (12),
        .CFG_WIDTH  (6),
        .CONV_CYCLES(CONV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .adc_convst (adc_convst),
        .adc_sck    (adc_sck),
        .adc_sdi    (adc_sdi),
        .adc_sdo    (adc_sdo),
        .ch_sel     (ch_sel),
        .ch_data    (ch_data),
        .cfg_out    (cfg_out),
        .cfg_valid  (cfg_valid),
        .busy       (busy),
        .frame_error(frame_error)
    );

    always @(posedge clk) begin
        if (frame_error) fe_cnt++;
        if (cfg_valid) cv_cnt++;
    end

    typedef struct {
        logic [5:0]  cfg;
        logic [11:0] exp_data;
    } vec_t;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // CONVST pulse, then busy timing, SDO quiet during conversion and MSB timing.
    task automatic start_conv(input logic [11:0] exp, input bit early, input bit scramble);
        int hi;
        bit sdo_bad;
        adc_convst = 1'b1;
        wait_clk(2);
        check("busy_before_detect", busy, 0);
        wait_clk(1);
        adc_convst = 1'b0;
        check("busy_rise_3clk", busy, 1);
        if (scramble) for (int c = 0; c < 8; c++) src[c] = 12'($urandom);
        hi = 1;
        sdo_bad = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (early && hi == 20) adc_sck = 1'b1;
            if (early && hi == 26) adc_sck = 1'b0;
            wait_clk(1);
            if (!busy) break;
            hi++;
            if (adc_sdo !== 1'b0) sdo_bad = 1'b1;
        end
        check("busy_width", hi, CONV);
        check("sdo_low_in_convert", sdo_bad, 0);
        check("sdo_before_msb", adc_sdo, 0);
        wait_clk(1);
        check("msb_timing", adc_sdo, exp[11]);
    endtask

    task automatic shift_bits(input logic [5:0] cfg, input int n, output logic [11:0] rd);
        rd = '0;
        for (int i = 0; i < n; i++) begin
            adc_sdi = (i < 6) ? cfg[5-i] : 1'b0;
            wait_clk(4);
            rd[11-i] = adc_sdo;
            adc_sck = 1'b1;
            wait_clk(4);
            adc_sck = 1'b0;
        end
        adc_sdi = 1'b0;
    endtask

    task automatic run_frame(input logic [5:0] cfg, input logic [11:0] exp, input bit early,
                             input bit scramble);
        int fe0, cv0;
        logic [11:0] rd;
        fe0 = fe_cnt;
        cv0 = cv_cnt;
        start_conv(exp, early, scramble);
        shift_bits(cfg, 12, rd);
        wait_clk(6);
        check("sdo_data", rd, exp);
        check("cfg_out", cfg_out, cfg);
        check("cfg_valid_pulses", cv_cnt - cv0, 1);
        check("frame_error_pulses", fe_cnt - fe0, early ? 1 : 0);
        check("ch_sel", ch_sel, cfg[4:2]);
        check("sdo_idle", adc_sdo, 0);
        model_cfg = cfg;
    endtask

    initial begin
        vec_t        vecs [7];
        logic [11:0] rd, exp;
        logic [5:0]  cfg;
        int          fe0, cv0;

        src[0] = 12'hA5C; src[1] = 12'h123; src[2] = 12'hFFF; src[3] = 12'h000;
        src[4] = 12'h801; src[5] = 12'h064; src[6] = 12'h5A3; src[7] = 12'h3C7;
        // Each row reads the channel chosen by the previous row's config.
        vecs[0] = '{cfg: 6'b100010, exp_data: 12'hA5C};
        vecs[1] = '{cfg: 6'b010100, exp_data: 12'hA5C};
        vecs[2] = '{cfg: 6'b000000, exp_data: 12'h064};
        vecs[3] = '{cfg: 6'b111111, exp_data: 12'hA5C};
        vecs[4] = '{cfg: 6'b001000, exp_data: 12'h3C7};
        vecs[5] = '{cfg: 6'b000100, exp_data: 12'hFFF};
        vecs[6] = '{cfg: 6'b000000, exp_data: 12'h123};

        reset = 1'b1; adc_convst = 1'b0; adc_sck = 1'b0; adc_sdi = 1'b0;
        model_cfg = '0;
        wait_clk(4);
        reset = 1'b0;
        wait_clk(1);
        check("reset_sdo", adc_sdo, 0);
        check("reset_busy", busy, 0);
        check("reset_cfg_valid", cfg_valid, 0);
        check("reset_frame_error", frame_error, 0);
        check("reset_cfg_out", cfg_out, 0);
        check("reset_ch_sel", ch_sel, 0);

        foreach (vecs[i]) run_frame(vecs[i].cfg, vecs[i].exp_data, 1'b0, 1'b0);

        // SCK rise during conversion flags an error but the frame still completes.
        run_frame(6'b101001, src[model_cfg[4:2]], 1'b1, 1'b0);

        // CONVST after 5 SCK aborts; new sample latched, config kept.
        fe0 = fe_cnt;
        cv0 = cv_cnt;
        start_conv(src[model_cfg[4:2]], 1'b0, 1'b0);
        shift_bits(6'b011100, 5, rd);
        for (int c = 0; c < 8; c++) src[c] = 12'($urandom);
        exp = src[model_cfg[4:2]];
        start_conv(exp, 1'b0, 1'b0);
        check("abort_frame_error", fe_cnt - fe0, 1);
        check("abort_no_cfg_valid", cv_cnt - cv0, 0);
        check("abort_cfg_kept", cfg_out, model_cfg);
        shift_bits(6'b110110, 12, rd);
        wait_clk(6);
        check("abort_new_data", rd, exp);
        check("abort_new_cfg", cfg_out, 6'b110110);
        check("abort_cfg_valid", cv_cnt - cv0, 1);
        model_cfg = 6'b110110;

        // Reset mid-SHIFT.
        fe0 = fe_cnt;
        start_conv(src[model_cfg[4:2]], 1'b0, 1'b0);
        shift_bits(6'b000000, 5, rd);
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        check("midreset_sdo", adc_sdo, 0);
        check("midreset_busy", busy, 0);
        check("midreset_cfg_out", cfg_out, 0);
        check("midreset_ch_sel", ch_sel, 0);
        check("midreset_cfg_valid", cfg_valid, 0);
        wait_clk(2);
        check("midreset_no_frame_error", fe_cnt - fe0, 0);
        model_cfg = '0;
        run_frame(6'b000000, src[0], 1'b0, 1'b0);

        // Boundary and walking-bit codes on channel 0.
        for (int i = 0; i < 26; i++) begin
            if (i == 0) src[0] = 12'h000;
            else if (i == 1) src[0] = 12'hFFF;
            else if (i < 14) src[0] = 12'(1) << (i - 2);
            else src[0] = ~(12'(1) << (i - 14));
            run_frame(6'b000000, src[0], 1'b0, 1'b0);
        end

        // Random configs and sources, source scrambled after the sample is latched.
        for (int i = 0; i < 40; i++) begin
            for (int c = 0; c < 8; c++) src[c] = 12'($urandom);
            cfg = 6'($urandom);
            exp = src[model_cfg[4:2]];
            run_frame(cfg, exp, 1'b0, 1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
